// File: rtl/rob_ring.sv
// rob_ring: circular reorder buffer with multi-port writeback and in-order multi-lane commit.
// Optional feature macro ROB_EXCEPTION_FLUSH_EN: an excepting head entry flushes the ring instead of retiring.
module rob_ring #(
    parameter int DEPTH        = 128,
    parameter int NUM_WB       = 2,
    parameter int COMMIT_WIDTH = 2,
    parameter int ADDR_BITS    = 32,
    parameter int PHYS_BITS    = 7,
    parameter int PTR_BITS     = $clog2(DEPTH)
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              alloc_valid_in,
    output logic                              alloc_ready_out,
    input  logic [ADDR_BITS-1:0]              alloc_pc_in,
    input  logic [PHYS_BITS-1:0]              alloc_dest_phys_in,
    output logic [PTR_BITS-1:0]               alloc_ptr_out,
    input  logic [NUM_WB-1:0]                 wb_valid_in,
    input  logic [NUM_WB*PTR_BITS-1:0]        wb_ptr_in,
    input  logic [NUM_WB-1:0]                 wb_exc_in,
    output logic [COMMIT_WIDTH-1:0]           commit_valid_out,
    output logic [COMMIT_WIDTH*PHYS_BITS-1:0] commit_dest_phys_out,
    output logic [COMMIT_WIDTH*ADDR_BITS-1:0] commit_pc_out,
    output logic                              flush_out,
    output logic [ADDR_BITS-1:0]              flush_pc_out,
    output logic [PTR_BITS:0]                 count_out
);

    localparam logic [1:0] ST_ISSUED = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;
    localparam logic [1:0] ST_EXC    = 2'd3;

    logic                 valid_q  [DEPTH];
    logic [1:0]           status_q [DEPTH];
    logic [ADDR_BITS-1:0] pc_q     [DEPTH];
    logic [PHYS_BITS-1:0] dest_q   [DEPTH];

    logic [PTR_BITS-1:0]  head_q, head_d;
    logic [PTR_BITS-1:0]  tail_q, tail_d;
    logic [PTR_BITS:0]    count_q, count_d;
    logic [PTR_BITS:0]    retireCnt;
    logic [PTR_BITS-1:0]  laneIdx;
    logic                 scanOn;
    logic                 allocFire;

    // Without the flush feature an excepting uop simply retires like a completed one.
    function automatic logic canRetire(input logic [1:0] st);
`ifdef ROB_EXCEPTION_FLUSH_EN
        return st == ST_DONE;
`else
        return (st == ST_DONE) || (st == ST_EXC);
`endif
    endfunction

    always_comb begin
        commit_valid_out     = '0;
        commit_pc_out        = '0;
        commit_dest_phys_out = '0;
        retireCnt            = '0;
        laneIdx              = head_q;
        scanOn               = 1'b1;
        for (int i = 0; i < COMMIT_WIDTH; i++) begin
            laneIdx = head_q + PTR_BITS'(i);
            if (scanOn && valid_q[laneIdx] && canRetire(status_q[laneIdx])) begin
                commit_valid_out[i]                            = 1'b1;
                commit_pc_out[i*ADDR_BITS +: ADDR_BITS]        = pc_q[laneIdx];
                commit_dest_phys_out[i*PHYS_BITS +: PHYS_BITS] = dest_q[laneIdx];
                retireCnt                                      = retireCnt + 1'b1;
            end else begin
                scanOn = 1'b0;
            end
        end
    end

`ifdef ROB_EXCEPTION_FLUSH_EN
    assign flush_out    = valid_q[head_q] && (status_q[head_q] == ST_EXC);
    assign flush_pc_out = flush_out ? pc_q[head_q] : '0;
`else
    assign flush_out    = 1'b0;
    assign flush_pc_out = '0;
`endif

    assign alloc_ready_out = (count_q < (PTR_BITS+1)'(DEPTH)) && !flush_out;
    assign alloc_ptr_out   = tail_q;
    assign count_out       = count_q;
    assign allocFire       = alloc_valid_in && alloc_ready_out;

    always_comb begin
        head_d  = head_q + retireCnt[PTR_BITS-1:0];
        tail_d  = tail_q + PTR_BITS'(allocFire);
        count_d = count_q + (PTR_BITS+1)'(allocFire) - retireCnt;
    end

    // Writebacks are applied in port order so the highest-numbered port wins on a shared tag.
    always_ff @(posedge clk_in) begin
        if (rst_in || flush_out) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            for (int p = 0; p < NUM_WB; p++) begin
                if (wb_valid_in[p] && valid_q[wb_ptr_in[p*PTR_BITS +: PTR_BITS]]) begin
                    status_q[wb_ptr_in[p*PTR_BITS +: PTR_BITS]] <= wb_exc_in[p] ? ST_EXC : ST_DONE;
                end
            end
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (commit_valid_out[i]) begin
                    valid_q[head_q + PTR_BITS'(i)] <= 1'b0;
                end
            end
            if (allocFire) begin
                valid_q[tail_q]  <= 1'b1;
                status_q[tail_q] <= ST_ISSUED;
                pc_q[tail_q]     <= alloc_pc_in;
                dest_q[tail_q]   <= alloc_dest_phys_in;
            end
        end
    end

endmodule

// File: tb/tb_rob_ring.sv
// tb_rob_ring: directed and randomized scoreboard bench for rob_ring (DEPTH=8, two writeback ports, two commit lanes).
// Follows ROB_EXCEPTION_FLUSH_EN in its reference model so it matches either build.
module tb_rob_ring;

   localparam int DEPTH = 8;
   localparam int NW    = 2;
   localparam int CW    = 2;
   localparam int AB    = 32;
   localparam int PB    = 7;
   localparam int PTRB  = 3;

   logic             clk;
   logic             rst;
   logic             allocValid;
   logic             allocReady;
   logic [AB-1:0]    allocPc;
   logic [PB-1:0]    allocDest;
   logic [PTRB-1:0]  allocPtr;
   logic [NW-1:0]    wbValid;
   logic [NW*PTRB-1:0] wbPtr;
   logic [NW-1:0]    wbExc;
   logic [CW-1:0]    commitValid;
   logic [CW*PB-1:0] commitDest;
   logic [CW*AB-1:0] commitPc;
   logic             flush;
   logic [AB-1:0]    flushPc;
   logic [PTRB:0]    count;

   rob_ring #(.DEPTH(DEPTH), .NUM_WB(NW), .COMMIT_WIDTH(CW), .ADDR_BITS(AB), .PHYS_BITS(PB)) dut (
      .clk_in(clk), .rst_in(rst),
      .alloc_valid_in(allocValid), .alloc_ready_out(allocReady),
      .alloc_pc_in(allocPc), .alloc_dest_phys_in(allocDest), .alloc_ptr_out(allocPtr),
      .wb_valid_in(wbValid), .wb_ptr_in(wbPtr), .wb_exc_in(wbExc),
      .commit_valid_out(commitValid), .commit_dest_phys_out(commitDest), .commit_pc_out(commitPc),
      .flush_out(flush), .flush_pc_out(flushPc), .count_out(count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: in-flight uops in program order, status 1=issued 2=done 3=exception.
   typedef struct { logic [AB-1:0] pc; logic [PB-1:0] dest; int st; } ent_t;
   typedef struct { logic [AB-1:0] pc; logic [PB-1:0] dest; } cm_t;
   ent_t mq[$];
   cm_t  expQ[$];
   int   headTag = 0;
   int   tailTag = 0;
   int   checks = 0;
   int   failures = 0;

   function automatic bit retireOk(input int st);
`ifdef ROB_EXCEPTION_FLUSH_EN
      return st == 2;
`else
      return st == 2 || st == 3;
`endif
   endfunction

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input bit r, input bit aV, input logic [AB-1:0] pc, input logic [PB-1:0] d,
                                input logic [1:0] wv, input int t0, input int t1, input logic [1:0] we);
      int  n;
      bit  fl;
      bit  expReady;
      int  tp;
      int  k;
      ent_t e;
      cm_t c;
      @(negedge clk);
      rst        = r;
      allocValid = aV;
      allocPc    = pc;
      allocDest  = d;
      wbValid    = wv;
      wbPtr      = {t1[PTRB-1:0], t0[PTRB-1:0]};
      wbExc      = we;
      #1;
      n = 0;
      while (n < CW && n < mq.size() && retireOk(mq[n].st)) n++;
      fl = 1'b0;
`ifdef ROB_EXCEPTION_FLUSH_EN
      fl = (mq.size() > 0) && (mq[0].st == 3);
`endif
      expReady = (mq.size() < DEPTH) && !fl;
      checkOutput("alloc_ready", 64'(allocReady), 64'(expReady));
      checkOutput("alloc_ptr", 64'(allocPtr), 64'(tailTag));
      checkOutput("count", 64'(count), 64'(mq.size()));
      checkOutput("flush", 64'(flush), 64'(fl));
      checkOutput("flush_pc", 64'(flushPc), fl ? 64'(mq[0].pc) : 64'd0);
      checkOutput("commit_lanes", 64'($countones(commitValid)), 64'(n));
      for (int i = 0; i < n; i++) begin
         c.pc   = mq[i].pc;
         c.dest = mq[i].dest;
         expQ.push_back(c);
      end
      @(posedge clk);
      if (r || fl) begin
         mq.delete();
         headTag = 0;
         tailTag = 0;
      end else begin
         for (int p = 0; p < NW; p++) begin
            if (wv[p]) begin
               tp = (p == 0) ? t0 : t1;
               k  = (tp - headTag + DEPTH) % DEPTH;
               if (k < mq.size()) mq[k].st = we[p] ? 3 : 2;
            end
         end
         for (int i = 0; i < n; i++) void'(mq.pop_front());
         headTag = (headTag + n) % DEPTH;
         if (aV && expReady) begin
            e.pc   = pc;
            e.dest = d;
            e.st   = 1;
            mq.push_back(e);
            tailTag = (tailTag + 1) % DEPTH;
         end
      end
   endtask

   // Monitor: whenever the DUT presents retiring lanes, pop and compare against the scoreboard.
   initial begin
      cm_t e;
      forever begin
         @(negedge clk);
         #2;
         if (commitValid[1] && !commitValid[0]) begin
            checks++;
            failures++;
            $display("[TB] FAIL commit_thermometer actual=%b required=01 or 11", commitValid);
         end
         for (int l = 0; l < CW; l++) begin
            if (commitValid[l] === 1'b1) begin
               if (expQ.size() == 0) begin
                  checks++;
                  failures++;
                  $display("[TB] FAIL commit_extra lane=%0d actual=retire required=none", l);
               end else begin
                  e = expQ.pop_front();
                  checkOutput("commit_pc", 64'(commitPc[l*AB +: AB]), 64'(e.pc));
                  checkOutput("commit_dest", 64'(commitDest[l*PB +: PB]), 64'(e.dest));
               end
            end
         end
      end
   end

   initial begin
      bit   aV;
      logic [1:0] wv;
      logic [1:0] we;
      int   t0;
      int   t1;
      rst = 1'b1; allocValid = 1'b0; allocPc = '0; allocDest = '0;
      wbValid = '0; wbPtr = '0; wbExc = '0;
      repeat (2) @(posedge clk);

      // Three uops completed out of order; lanes hold until tag 0 completes.
      applyStimulus(0, 1, 32'h100, 7'd10, 2'b00, 0, 0, 2'b00);
      applyStimulus(0, 1, 32'h104, 7'd11, 2'b00, 0, 0, 2'b00);
      applyStimulus(0, 1, 32'h108, 7'd12, 2'b00, 0, 0, 2'b00);
      applyStimulus(0, 0, 32'h0, 7'd0, 2'b01, 2, 0, 2'b00);
      applyStimulus(0, 0, 32'h0, 7'd0, 2'b01, 0, 0, 2'b00);
      applyStimulus(0, 0, 32'h0, 7'd0, 2'b01, 1, 0, 2'b00);
      repeat (3) applyStimulus(0, 0, 32'h0, 7'd0, 2'b00, 0, 0, 2'b00);

      // Fill to full, complete the head while alloc is held, then wrap the tail.
      applyStimulus(1, 0, 32'h0, 7'd0, 2'b00, 0, 0, 2'b00);
      for (int i = 0; i < DEPTH + 1; i++)
         applyStimulus(0, 1, 32'h400 + 32'(4*i), 7'(20 + i), 2'b00, 0, 0, 2'b00);
      applyStimulus(0, 1, 32'h500, 7'd40, 2'b01, 0, 0, 2'b00);
      repeat (3) applyStimulus(0, 1, 32'h504, 7'd41, 2'b00, 0, 0, 2'b00);

      // Both ports hit tag 3; port 1 reports an exception and must win.
      applyStimulus(0, 0, 32'h0, 7'd0, 2'b11, 3, 3, 2'b10);
      applyStimulus(0, 0, 32'h0, 7'd0, 2'b11, 1, 2, 2'b00);
      repeat (3) applyStimulus(0, 0, 32'h0, 7'd0, 2'b11, 4, 5, 2'b00);

      for (int cyc = 0; cyc < 800; cyc++) begin
         aV = ($urandom_range(0, 9) < 6);
         wv = 2'($urandom_range(0, 3));
         we[0] = ($urandom_range(0, 11) == 0);
         we[1] = ($urandom_range(0, 11) == 0);
         if (mq.size() > 0) begin
            t0 = (headTag + $urandom_range(0, mq.size())) % DEPTH;
            t1 = (headTag + $urandom_range(0, mq.size())) % DEPTH;
         end else begin
            t0 = $urandom_range(0, DEPTH - 1);
            t1 = $urandom_range(0, DEPTH - 1);
         end
         applyStimulus(($urandom_range(0, 99) == 0), aV, 32'($urandom) & 32'hFFFF_FFFC,
                       7'($urandom), wv, t0, t1, we);
      end

      #5;
      checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
